// File: rtl/t_pulse_gen.sv
// Programmable toggle-enable generator feeding a T flip-flop: single-cycle t
// pulses every period cycles, either for a fixed count or until aborted.
module t_pulse_gen #(
  parameter int unsigned PER_W = 8,
  parameter int unsigned NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             continuous,
  input  logic [PER_W-1:0] period,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             t,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulses_left
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [PER_W-1:0] r_cnt;
  logic [PER_W-1:0] r_per;
  logic             r_cont;
  logic             r_t;
  logic             r_busy;
  logic             r_done;
  logic [NUM_W-1:0] r_left;

  logic [PER_W-1:0] w_per_eff;
  logic             w_last;

  // A zero period is run as period 1, so r_per - 1 cannot wrap.
  assign w_per_eff = (period == '0) ? PER_W'(1) : period;
  assign w_last    = (r_cnt == r_per - PER_W'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_per   <= '0;
      r_cont  <= 1'b0;
      r_t     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_left  <= '0;
    end else begin
      r_t    <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (start && !abort) begin
            r_per  <= w_per_eff;
            r_cont <= continuous;
            r_cnt  <= '0;
            if (!continuous && (num_pulses == '0)) begin
              r_left  <= '0;
              r_state <= S_DONE;
            end else begin
              r_left  <= continuous ? '0 : num_pulses;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_left  <= '0;
            r_state <= S_IDLE;
          end else if (w_last) begin
            r_cnt <= '0;
            r_t   <= 1'b1;
            if (!r_cont) begin
              r_left <= r_left - NUM_W'(1);
              // busy stays high through the final t cycle and drops in DONE.
              if (r_left == NUM_W'(1)) begin
                r_state <= S_DONE;
              end
            end
          end else begin
            r_cnt <= r_cnt + PER_W'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign t           = r_t;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pulses_left = r_left;

endmodule

// File: tb/tb_t_pulse_gen.sv
// Directed bench for t_pulse_gen: one-shot, continuous, abort, collisions and
// reset, with expected values computed from the pulse schedule.
module tb_t_pulse_gen;

  localparam int unsigned PER_W = 8;
  localparam int unsigned NUM_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic             continuous;
  logic [PER_W-1:0] period;
  logic [NUM_W-1:0] num_pulses;
  logic             t;
  logic             busy;
  logic             done;
  logic [NUM_W-1:0] pulses_left;

  int n_checks = 0;
  int n_errors = 0;

  t_pulse_gen #(.PER_W(PER_W), .NUM_W(NUM_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .continuous  (continuous),
    .period      (period),
    .num_pulses  (num_pulses),
    .t           (t),
    .busy        (busy),
    .done        (done),
    .pulses_left (pulses_left)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int et, input int eb,
                            input int ed, input int el);
    check({tag, ".t"},    int'(t),           et);
    check({tag, ".busy"}, int'(busy),        eb);
    check({tag, ".done"}, int'(done),        ed);
    check({tag, ".left"}, int'(pulses_left), el);
  endtask

  // One-shot burst; k counts edges after the start edge, pulses land at k = p, 2p, ...
  task automatic run_oneshot(input string tag, input int p_in, input int n, input bit perturb);
    int p;
    int last;
    int et, eb, ed, el;
    bit q;
    p    = (p_in == 0) ? 1 : p_in;
    last = n * p;
    q    = 1'b0;
    period     = PER_W'(p_in);
    num_pulses = NUM_W'(n);
    continuous = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check_outs($sformatf("%s.e0", tag), 0, (n != 0) ? 1 : 0, 0, n);
    for (int k = 1; k <= last + 3; k++) begin
      if (perturb && k == 5) begin
        start      = 1'b1;
        period     = PER_W'(p + 3);
        num_pulses = NUM_W'(n + 4);
      end
      if (perturb && k == 6) start = 1'b0;
      tick();
      et = ((k % p) == 0 && k <= last) ? 1 : 0;
      eb = (n != 0 && k <= last) ? 1 : 0;
      ed = (k == last + 1) ? 1 : 0;
      el = (k <= last) ? (n - k / p) : 0;
      check_outs($sformatf("%s.k%0d", tag, k), et, eb, ed, el);
      q ^= t;
    end
    check({tag, ".q"}, int'(q), n % 2);
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b1;
    abort      = 1'b0;
    continuous = 1'b0;
    period     = PER_W'(4);
    num_pulses = NUM_W'(3);

    // Reset held with start asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs($sformatf("rst%0d", i), 0, 0, 0, 0);
    end
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs($sformatf("post_rst%0d", i), 0, 0, 0, 0);
    end

    run_oneshot("os_p4n3", 4, 3, 1'b0);
    run_oneshot("os_p0n2", 0, 2, 1'b0);
    run_oneshot("os_p3n0", 3, 0, 1'b0);

    // Continuous period 2, aborted after the fifth pulse
    period     = PER_W'(2);
    num_pulses = NUM_W'(9);
    continuous = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check_outs("cont.e0", 0, 1, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_outs($sformatf("cont.k%0d", k), ((k % 2) == 0) ? 1 : 0, 1, 0, 0);
    end
    abort = 1'b1;
    tick();
    abort      = 1'b0;
    continuous = 1'b0;
    check_outs("cont.abort", 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_outs($sformatf("cont.post%0d", k), 0, 0, 0, 0);
    end

    // start and abort together in IDLE
    period     = PER_W'(1);
    num_pulses = NUM_W'(2);
    start      = 1'b1;
    abort      = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_outs("sa.e0", 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_outs($sformatf("sa.k%0d", k), 0, 0, 0, 0);
    end

    // Restart and period change mid-burst must not disturb the burst
    run_oneshot("os_perturb", 4, 3, 1'b1);

    // Reset mid-burst at pulses_left == 2
    period     = PER_W'(4);
    num_pulses = NUM_W'(3);
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    check_outs("mid.k5", 0, 1, 0, 2);
    rst = 1'b0;
    tick();
    check_outs("mid.rst", 0, 0, 0, 0);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_outs($sformatf("mid.post%0d", k), 0, 0, 0, 0);
    end
    run_oneshot("os_after_rst", 4, 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/t_pulse_gen.md
Name: t_pulse_gen

Overview:
Programmable toggle-enable generator that sits directly upstream of the T flip-flop and drives its t input. It produces single-cycle t pulses at a programmable period, either for a fixed pulse count (one-shot burst) or until aborted (continuous). The T flip-flop therefore toggles q at a controlled rate and count.

Parameters:
PER_W, 8, width of the period input and the internal prescale counter
NUM_W, 8, width of the pulse-count input and the pulses_left output

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low; sampled on rising clk edge
start  input  1  request to begin a burst; sampled only in IDLE
abort  input  1  stop current burst; effective in any state
continuous  input  1  1 = pulse until abort; 0 = pulse num_pulses times; latched on start
period  input  PER_W  cycles between t pulses; latched on start; 0 treated as 1
num_pulses  input  NUM_W  burst length in one-shot mode; latched on start
t  output  1  registered single-cycle toggle-enable pulse to the T flip-flop
busy  output  1  registered; high while a burst is in progress
done  output  1  registered; one-cycle completion strobe (one-shot mode only)
pulses_left  output  NUM_W  registered; remaining pulses in one-shot mode; 0 in continuous mode

Behaviour:
- Reset: rst==0 at a rising edge -> state IDLE, t=0, busy=0, done=0, pulses_left=0, prescale counter=0, latched regs=0. Reset overrides all other inputs, including mid-burst.
- FSM states: IDLE, RUN, DONE. All outputs are registered; none are combinational from inputs.
- IDLE: t=0, busy=0. At an edge with start=1 and abort=0: latch period (0 -> 1), continuous, and num_pulses; counter=0.
  - Go to RUN with busy=1 and pulses_left=num_pulses (0 if continuous).
  - One-shot with num_pulses==0: go to DONE instead (busy=0); no t pulse is issued.
  - start=1 and abort=1 together: stay IDLE.
- RUN: counter increments each edge. At the edge where counter==period_l-1: counter=0, t=1 for the following cycle. All other edges: t=0.
  - Latency: start sampled at edge E0 gives the first t high in the cycle after edge E0+period_l. Subsequent t pulses are exactly period_l cycles apart.
  - period_l==1: t is high every cycle.
  - One-shot: pulses_left decrements at the same edge t is set. When it reaches 0, go to DONE at that edge and clear busy at the next edge.
  - Continuous: pulses_left holds 0; run until abort.
- DONE: lasts one cycle. At its entry edge t=0, busy=0, and done=1 for exactly one cycle. Next edge: IDLE, done=0.
  - A start arriving while in DONE is ignored.
- abort=1 at any edge in RUN: t=0, busy=0, counter=0, pulses_left=0, go to IDLE. done is not asserted.
  - abort in DONE: done still completes its single cycle.
- start while busy is ignored. Latched period, num_pulses and continuous do not change mid-burst if the inputs change.
- Counter width is PER_W; period_l-1 never underflows because period 0 is mapped to 1.

Test Plan:
1. Reset: hold rst=0 for 3 edges with start=1 -> t=0, busy=0, done=0, pulses_left=0 throughout; nothing starts after release until a new start.
2. One-shot: period=4, num_pulses=3, continuous=0, start for 1 cycle.
   - t high exactly 3 times, in cycles 4, 8 and 12 after the start edge.
   - pulses_left steps 3->2->1->0.
   - done is a single cycle right after the third pulse; busy is low from then on.
   - With a downstream T flip-flop starting at q=0, q ends at 1.
3. Period edge cases:
   - period=0, num_pulses=2 -> t high for 2 consecutive cycles, then done.
   - num_pulses=0, one-shot -> no t pulse; done asserted in the cycle after start.
4. Continuous: period=2, continuous=1 -> t alternates 0/1 indefinitely and pulses_left=0. Abort after 5 pulses -> t=0 and busy=0 from the next cycle; no done.
5. Collisions:
   - start+abort in the same cycle in IDLE -> stays IDLE.
   - start pulsed again mid-burst -> ignored; burst count unchanged.
   - period input changed mid-burst -> pulse spacing unchanged.
6. Reset mid-burst: rst=0 while pulses_left=2 -> all outputs 0 at the next edge; done is never asserted; a new start after release behaves as in scenario 2.
